spi_adc_multich_fifo_wr: RTL and testbench

Parametrised multi-channel SPI ADC reader with byte-serialised FIFO write port. Captures one SPI frame per conversion from NUM_CH parallel serial data lines that share cs_n and sclk. Unpacks each channel's sample into bytes and pushes them into a downstream byte-wide FIFO, honouring FIFO back-pressure. Supports single-shot and free-running modes and flags dropped triggers.

---
 rtl/spi_adc_pkg.sv | 26 ++
 rtl/spi_sclk_gen.sv | 43 ++++
 rtl/spi_adc_multich_fifo_wr.sv | 140 ++++++++++++++
 tb/tb_spi_adc_multich_fifo_wr.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel SPI ADC reader.
package spi_adc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_LEAD,
        S_SHIFT,
        S_QUIET,
        S_WRITE,
        S_DONE
    } adc_state_t;

    function automatic int bytes_per_sample(input int sample_bits);
        return (sample_bits > 8) ? 2 : 1;
    endfunction

    function automatic bit params_legal(input int num_ch, input int frame_bits,
                                        input int sample_bits, input int clk_div);
        return (num_ch >= 1) && (num_ch <= 8) &&
               (frame_bits >= 2) && (frame_bits <= 32) &&
               (sample_bits >= 1) && (sample_bits <= 16) &&
               (sample_bits <= frame_bits) &&
               (clk_div >= 1) && (clk_div <= 65535);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: divider, registered CPOL=0 sclk, rise tick and end-of-frame flag.
module spi_sclk_gen #(
    parameter int CLK_DIV    = 5,
    parameter int FRAME_BITS = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_frame_end
);

    logic [15:0] r_div;
    logic [6:0]  r_tog;
    logic        r_sclk;
    logic        w_tc;

    assign w_tc        = i_en && (r_div == 16'(CLK_DIV - 1));
    // Tick cycle is the one in which sclk is about to go 0->1; data is captured here.
    assign o_rise      = w_tc && !r_sclk;
    assign o_frame_end = w_tc && (r_tog == 7'(2 * FRAME_BITS - 1));
    assign o_sclk      = r_sclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= '0;
            r_tog  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_div  <= '0;
            r_tog  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tc) begin
            r_div  <= '0;
            r_tog  <= r_tog + 7'd1;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + 16'd1;
        end
    end

endmodule

// File: rtl/spi_adc_multich_fifo_wr.sv
// Multi-channel SPI ADC frame capture with byte-serialised, back-pressured FIFO write port.
module spi_adc_multich_fifo_wr
    import spi_adc_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int FRAME_BITS  = 16,
    parameter int SAMPLE_BITS = 12,
    parameter int CLK_DIV     = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] din,
    input  logic              fifo_full,
    output logic              cs_n,
    output logic              sclk,
    output logic              fifo_wr_en,
    output logic [7:0]        fifo_wdata,
    output logic              ready,
    output logic              done,
    output logic              overrun
);

    localparam int          BYTES       = bytes_per_sample(SAMPLE_BITS);
    localparam int          NUM_WR      = NUM_CH * BYTES;
    localparam logic [15:0] SAMPLE_MASK = 16'((32'd1 << SAMPLE_BITS) - 32'd1);

    if (!params_legal(NUM_CH, FRAME_BITS, SAMPLE_BITS, CLK_DIV)) begin : g_bad_params
        $error("spi_adc_multich_fifo_wr: illegal parameter combination");
    end

    adc_state_t            r_state;
    adc_state_t            w_state_next;
    logic [15:0]           r_wait;
    logic                  w_wait_done;
    logic [3:0]            r_k;
    logic                  w_last_k;
    logic [3:0]            w_ch;
    logic                  w_hi;
    logic [15:0]           w_sample;
    logic [7:0]            w_byte;
    logic [FRAME_BITS-1:0] r_shift [NUM_CH];
    logic                  w_sclk_en;
    logic                  w_rise;
    logic                  w_frame_end;

    assign w_wait_done = (r_wait == 16'(CLK_DIV - 1));
    assign w_last_k    = (r_k == 4'(NUM_WR - 1));
    assign w_sclk_en   = (r_state == S_SHIFT);

    spi_sclk_gen #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_sclk_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_en        (w_sclk_en),
        .o_sclk      (sclk),
        .o_rise      (w_rise),
        .o_frame_end (w_frame_end)
    );

    // Byte k maps to channel k/BYTES; odd k is the zero-padded high byte when BYTES=2.
    always_comb begin
        w_ch     = (BYTES == 2) ? (r_k >> 1) : r_k;
        w_hi     = (BYTES == 2) && r_k[0];
        w_sample = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(w_ch) == i) w_sample = 16'(r_shift[i]) & SAMPLE_MASK;
        end
        w_byte = w_hi ? w_sample[15:8] : w_sample[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        cs_n         = 1'b1;
        fifo_wr_en   = 1'b0;
        fifo_wdata   = '0;
        ready        = 1'b0;
        done         = 1'b0;
        overrun      = sample && !continuous && (r_state != S_IDLE) && (r_state != S_DONE);
        unique case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (sample || continuous) w_state_next = S_CS_LEAD;
            end
            S_CS_LEAD: begin
                cs_n = 1'b0;
                if (w_wait_done) w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                cs_n = 1'b0;
                if (w_frame_end) w_state_next = S_QUIET;
            end
            S_QUIET: begin
                if (w_wait_done) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                fifo_wr_en = !fifo_full;
                fifo_wdata = w_byte;
                if (!fifo_full && w_last_k) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = continuous ? S_CS_LEAD : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait <= '0;
            r_k    <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) r_shift[i] <= '0;
        end else begin
            if (((r_state == S_CS_LEAD) || (r_state == S_QUIET)) && !w_wait_done)
                r_wait <= r_wait + 16'd1;
            else
                r_wait <= '0;

            if (r_state != S_WRITE)
                r_k <= '0;
            else if (!fifo_full)
                r_k <= w_last_k ? '0 : r_k + 4'd1;

            if (w_rise) begin
                for (int unsigned i = 0; i < NUM_CH; i++)
                    r_shift[i] <= {r_shift[i][FRAME_BITS-2:0], din[i]};
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_multich_fifo_wr.sv
// Directed bench: default-parameter instance plus a minimal 1-channel 8-bit instance.
module tb_spi_adc_multich_fifo_wr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    logic       sample = 1'b0, continuous = 1'b0, fifo_full = 1'b0;
    logic [1:0] din = '0;
    logic       cs_n, sclk, fifo_wr_en, ready, done, overrun;
    logic [7:0] fifo_wdata;

    logic       sample2 = 1'b0, continuous2 = 1'b0, fifo_full2 = 1'b0;
    logic [0:0] din2 = '0;
    logic       cs_n2, sclk2, fifo_wr_en2, ready2, done2, overrun2;
    logic [7:0] fifo_wdata2;

    spi_adc_multich_fifo_wr #(
        .NUM_CH(2), .FRAME_BITS(16), .SAMPLE_BITS(12), .CLK_DIV(5)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .sample(sample), .continuous(continuous),
        .din(din), .fifo_full(fifo_full), .cs_n(cs_n), .sclk(sclk),
        .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .ready(ready),
        .done(done), .overrun(overrun)
    );

    spi_adc_multich_fifo_wr #(
        .NUM_CH(1), .FRAME_BITS(8), .SAMPLE_BITS(8), .CLK_DIV(1)
    ) u_dut8 (
        .clk(clk), .reset_n(reset_n), .sample(sample2), .continuous(continuous2),
        .din(din2), .fifo_full(fifo_full2), .cs_n(cs_n2), .sclk(sclk2),
        .fifo_wr_en(fifo_wr_en2), .fifo_wdata(fifo_wdata2), .ready(ready2),
        .done(done2), .overrun(overrun2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // ADC models: present the next frame bit MSB first, advancing after each sclk rise.
    logic [15:0] adc_word [2];
    logic [7:0]  word2 = '0;
    int          rc1 = 0, rc2 = 0;
    logic        sp1 = 1'b0, sp2 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (cs_n) rc1 = 0;
        else if (sclk && !sp1) rc1++;
        sp1 = sclk;
        for (int c = 0; c < 2; c++) din[c] = (rc1 < 16) ? adc_word[c][15 - rc1] : 1'b0;
        if (cs_n2) rc2 = 0;
        else if (sclk2 && !sp2) rc2++;
        sp2 = sclk2;
        din2[0] = (rc2 < 8) ? word2[7 - rc2] : 1'b0;
    end

    logic       clr = 1'b0;
    logic [7:0] wr_q[$];
    int         wr_cyc[$], done_q[$], fall_q[$], rise_q[$];
    int         ovr_cnt = 0, sclk_rises = 0;
    logic       cs_p = 1'b1, sc_p = 1'b0;
    logic [7:0] wr2_q[$];
    int         done2_q[$];
    int         cs_low2 = 0;
    always @(negedge clk) begin
        if (clr) begin
            wr_q.delete(); wr_cyc.delete(); done_q.delete(); fall_q.delete(); rise_q.delete();
            wr2_q.delete(); done2_q.delete();
            ovr_cnt = 0; sclk_rises = 0; cs_low2 = 0;
        end else begin
            if (fifo_wr_en) begin wr_q.push_back(fifo_wdata); wr_cyc.push_back(cyc); end
            if (done) done_q.push_back(cyc);
            if (overrun) ovr_cnt++;
            if (cs_p && !cs_n) fall_q.push_back(cyc);
            if (!cs_p && cs_n) rise_q.push_back(cyc);
            if (sclk && !sc_p) sclk_rises++;
            if (fifo_wr_en2) wr2_q.push_back(fifo_wdata2);
            if (done2) done2_q.push_back(cyc);
            if (!cs_n2) cs_low2++;
        end
        cs_p = cs_n;
        sc_p = sclk;
    end

    typedef struct {
        logic [15:0] ch0;
        logic [15:0] ch1;
        int          stall;
        logic [31:0] exp;   // byte k in bits [8k+7:8k]
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic trigger1(output int t);
        @(posedge clk); #1; sample = 1'b1; t = cyc;
        @(posedge clk); #1; sample = 1'b0;
    endtask

    task automatic wait_done1(input int n, input int limit);
        int k = 0;
        while (done_q.size() < n && k < limit) begin @(negedge clk); #1; k++; end
        if (done_q.size() < n) chk("done_timeout", done_q.size(), n);
    endtask

    task automatic check_bytes(input string nm, input int base, input logic [31:0] exp);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_byte%0d", nm, base + i),
                (base + i < wr_q.size()) ? 32'(wr_q[base + i]) : 32'hFFFF_FFFF, 32'(exp[8*i +: 8]));
    endtask

    task automatic run_vec(input int idx);
        vec_t  v;
        int    t, n, last;
        string s;
        v = vt[idx];
        s = $sformatf("v%0d", idx);
        adc_word[0] = v.ch0;
        adc_word[1] = v.ch1;
        clear_mon();
        trigger1(t);
        if (v.stall > 0) begin
            n = 0;
            while (wr_q.size() < 1 && n < 400) begin @(posedge clk); #1; n++; end
            fifo_full = 1'b1;
            repeat (v.stall) @(posedge clk);
            #1 fifo_full = 1'b0;
        end
        wait_done1(1, 400);
        repeat (3) @(negedge clk);
        #1;
        last = wr_cyc.size() - 1;
        chk({s, "_nwr"}, wr_q.size(), 4);
        check_bytes(s, 0, v.exp);
        chk({s, "_latency"}, (done_q.size() > 0) ? done_q[0] - t + 1 : -1, 176 + v.stall);
        chk({s, "_cs_low"}, (rise_q.size() > 0 && fall_q.size() > 0) ? rise_q[0] - fall_q[0] : -1, 165);
        chk({s, "_quiet"}, (wr_cyc.size() > 0 && rise_q.size() > 0) ? wr_cyc[0] - rise_q[0] : -1, 5);
        chk({s, "_stall_gap"}, (last == 3) ? wr_cyc[3] - wr_cyc[0] + 1 - 4 : -1, v.stall);
        chk({s, "_done_after_wr"}, (last >= 0 && done_q.size() > 0) ? done_q[0] - wr_cyc[last] : -1, 1);
        chk({s, "_ready"}, ready, 1);
        chk({s, "_overrun"}, ovr_cnt, 0);
    endtask

    initial begin
        int t, n;
        logic [7:0] sweep[2];
        vt[0] = '{16'h0ABC, 16'h0123, 0, 32'h0123_0ABC};
        vt[1] = '{16'hFABC, 16'h0123, 0, 32'h0123_0ABC};
        vt[2] = '{16'hFFFF, 16'h0000, 0, 32'h0000_0FFF};
        vt[3] = '{16'h5A5A, 16'hA5A5, 0, 32'h05A5_0A5A};
        vt[4] = '{16'h0ABC, 16'h0123, 3, 32'h0123_0ABC};
        adc_word[0] = '0;
        adc_word[1] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_cs_n2", cs_n2, 1);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_ready", ready, 1);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Free-running: three frames back to back, never passing through IDLE.
        adc_word[0] = 16'h0321;
        adc_word[1] = 16'h0FED;
        clear_mon();
        @(posedge clk); #1 continuous = 1'b1;
        wait_done1(3, 700);
        continuous = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("cont_frames", fall_q.size(), 3);
        chk("cont_nwr", wr_q.size(), 12);
        for (int f = 0; f < 3; f++) check_bytes("cont", 4 * f, 32'h0FED_0321);
        chk("cont_period1", (done_q.size() >= 2) ? done_q[1] - done_q[0] : -1, 175);
        chk("cont_period2", (done_q.size() >= 3) ? done_q[2] - done_q[1] : -1, 175);
        chk("cont_cs_gap", (fall_q.size() >= 2 && rise_q.size() >= 1) ? fall_q[1] - rise_q[0] : -1, 10);
        chk("cont_overrun", ovr_cnt, 0);

        // Trigger arriving mid-SHIFT is dropped and flagged.
        adc_word[0] = 16'h0777;
        adc_word[1] = 16'h0888;
        clear_mon();
        trigger1(t);
        n = 0;
        while (sclk_rises < 3 && n < 200) begin @(negedge clk); #1; n++; end
        chk("ovr_reach_shift", (sclk_rises >= 3) ? 1 : 0, 1);
        @(posedge clk); #1 sample = 1'b1;
        @(posedge clk); #1 sample = 1'b0;
        wait_done1(1, 400);
        repeat (400) @(posedge clk);
        #1;
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_nwr", wr_q.size(), 4);
        check_bytes("ovr", 0, 32'h0888_0777);
        chk("ovr_frames", fall_q.size(), 1);
        chk("ovr_dones", done_q.size(), 1);

        // Asynchronous reset in the middle of the 7th sclk high phase.
        adc_word[0] = 16'h0AAA;
        adc_word[1] = 16'h0555;
        clear_mon();
        trigger1(t);
        n = 0;
        while (sclk_rises < 7 && n < 500) begin @(negedge clk); #1; n++; end
        chk("rst_mid_reach", sclk_rises, 7);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_cs_n", cs_n, 1);
        chk("rst_mid_sclk", sclk, 0);
        chk("rst_mid_wr_en", fifo_wr_en, 0);
        chk("rst_mid_ready", ready, 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("rst_mid_no_wr", wr_q.size(), 0);
        chk("rst_mid_no_done", done_q.size(), 0);
        run_vec(0);

        // Minimal configuration: 1 channel, 8-bit frame and sample, CLK_DIV=1.
        sweep[0] = 8'hA7;
        sweep[1] = 8'h3C;
        for (int i = 0; i < 2; i++) begin
            word2 = sweep[i];
            clear_mon();
            @(posedge clk); #1 sample2 = 1'b1; t = cyc;
            @(posedge clk); #1 sample2 = 1'b0;
            n = 0;
            while (done2_q.size() < 1 && n < 100) begin @(negedge clk); #1; n++; end
            repeat (3) @(negedge clk);
            #1;
            chk($sformatf("p%0d_nwr", i), wr2_q.size(), 1);
            chk($sformatf("p%0d_byte", i), (wr2_q.size() > 0) ? 32'(wr2_q[0]) : 32'hFFFF_FFFF, 32'(sweep[i]));
            chk($sformatf("p%0d_cs_low", i), cs_low2, 17);
            chk($sformatf("p%0d_latency", i), (done2_q.size() > 0) ? done2_q[0] - t + 1 : -1, 21);
            chk($sformatf("p%0d_ready", i), ready2, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
